// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: one outstanding word fetch,
// fixed wait-state latency, response held under decode back-pressure, flushable.
module imem_responder #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          flush,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_addr,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic [1:0]    dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and the payload is held while valid & !ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [31:0] mem_q [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic        rsp_err_q, rsp_err_d;

  logic          accept;
  logic          load_rsp;
  logic [31:0]   rd_addr;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic [31:0]   rd_word;

  // Program-load port; no reset so the image survives a fetch-side reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign req_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
  assign accept    = req_valid && req_ready;

  // With zero wait states the array is read on the accept edge itself.
  assign rd_addr = (state_q == S_WAIT) ? addr_q : req_addr;
  assign rd_idx  = rd_addr[AW+1:2];
  assign rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr >= ADDR_LIMIT);
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    load_rsp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (WAIT_STATES == 0) begin
            state_d  = S_RESP;
            load_rsp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          load_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            addr_d = req_addr;
            if (WAIT_STATES == 0) begin
              state_d  = S_RESP;
              load_rsp = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_LOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A redirect wins over everything; a same-cycle handshake is already consumed.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = 4'd0;
      load_rsp = 1'b0;
    end
  end

  always_comb begin
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    if (load_rsp) begin
      rsp_instr_d = rd_err ? NOP_INSTR : rd_word;
      rsp_addr_d  = rd_addr;
      rsp_err_d   = rd_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      rsp_instr_q <= 32'd0;
      rsp_addr_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_instr   = rsp_instr_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule
